// File: rtl/axis_rr_if.sv
`timescale 1ns/1ps
// axis_rr_if: AXI-Stream bundle joining NUM_SRC sources and one sink through the arbiter
interface axis_rr_if #(
  parameter int NUM_SRC = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int ID_W = $clog2(NUM_SRC)
);
  logic [NUM_SRC*TDATA_WIDTH-1:0] S_AXIS_TDATA;
  logic [NUM_SRC-1:0] S_AXIS_TVALID;
  logic [NUM_SRC-1:0] S_AXIS_TREADY;
  logic [TDATA_WIDTH-1:0] M_AXIS_TDATA;
  logic M_AXIS_TVALID;
  logic M_AXIS_TREADY;
  logic [ID_W-1:0] M_AXIS_TID;
  modport master (
    output S_AXIS_TDATA, S_AXIS_TVALID, M_AXIS_TREADY,
    input  S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TID
  );
  modport slave (
    input  S_AXIS_TDATA, S_AXIS_TVALID, M_AXIS_TREADY,
    output S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TID
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
`timescale 1ns/1ps
// axis_rr_arbiter: round-robin burst arbiter of NUM_SRC AXI-Stream sources into one registered sink port
// Optional per-source accepted-beat counters are built when AXIS_ARB_STATS_EN is defined.
module axis_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int MAX_BURST = 16
) (
  input logic clk,
  input logic rst_n,
`ifdef AXIS_ARB_STATS_EN
  input logic STAT_CLR,
  output logic [NUM_SRC*32-1:0] STAT_BEATS,
`endif
  axis_rr_if.slave bus
);
  localparam int ID_W = $clog2(NUM_SRC);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, gnt_q, gnt_d, tid_q, tid_d, sel, idx, gnt_nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic vld_q, vld_d, rdy, acc, gvld;
  logic [TDATA_WIDTH-1:0] data_q, data_d;
  logic [TDATA_WIDTH-1:0] src_data [NUM_SRC];
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_data[i] = bus.S_AXIS_TDATA[i*TDATA_WIDTH +: TDATA_WIDTH];
  end
  // Walk downward so the valid source closest at/after ptr wins; indices stay below NUM_SRC.
  always_comb begin
    sel = ptr_q;
    idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr_q) + k) % NUM_SRC);
      if (bus.S_AXIS_TVALID[idx]) sel = idx;
    end
  end
  assign gvld = bus.S_AXIS_TVALID[gnt_q];
  assign rdy = !vld_q || bus.M_AXIS_TREADY;
  assign acc = state_q == GRANT && gvld && rdy;
  assign gnt_nxt = gnt_q == ID_W'(NUM_SRC - 1) ? '0 : gnt_q + 1'b1;
  assign bus.S_AXIS_TREADY = (state_q == GRANT && rdy) ? NUM_SRC'(1) << gnt_q : '0;
  assign bus.M_AXIS_TDATA = data_q;
  assign bus.M_AXIS_TVALID = vld_q;
  assign bus.M_AXIS_TID = tid_q;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    cnt_d = acc ? cnt_q + 1'b1 : cnt_q;
    vld_d = acc || (vld_q && !bus.M_AXIS_TREADY);
    data_d = acc ? src_data[gnt_q] : data_q;
    tid_d = acc ? gnt_q : tid_q;
    if (state_q == IDLE) begin
      if (|bus.S_AXIS_TVALID) begin
        state_d = GRANT;
        gnt_d = sel;
        cnt_d = '0;
      end
    end else if (!gvld || (acc && cnt_q == CW'(MAX_BURST - 1))) begin
      state_d = IDLE;
      ptr_d = gnt_nxt;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gnt_q <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
      data_q <= '0;
      tid_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      data_q <= data_d;
      tid_q <= tid_d;
    end
`ifdef AXIS_ARB_STATS_EN
  // Clear has priority over a same-cycle accept.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_stat
    logic [31:0] beats_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) beats_q <= '0;
      else if (STAT_CLR) beats_q <= '0;
      else if (acc && gnt_q == ID_W'(i)) beats_q <= beats_q + 1'b1;
    assign STAT_BEATS[i*32 +: 32] = beats_q;
  end
`endif
endmodule

// File: tb/tb_axis_rr_arbiter.sv
`timescale 1ns/1ps
// tb_axis_rr_arbiter: directed source streams checked against a per-source sequence scoreboard
// Source beats carry {src[7:0], seq[23:0]} so loss, duplication and reordering are visible at the sink.
module tb_axis_rr_arbiter;
  localparam int N = 4, W = 32, MB = 4;
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;
  axis_rr_if #(.NUM_SRC(N), .TDATA_WIDTH(W), .ID_W(2)) bus ();
`ifdef AXIS_ARB_STATS_EN
  logic stat_clr = 1'b0;
  logic [N*32-1:0] stat_beats;
`endif
  axis_rr_arbiter #(.NUM_SRC(N), .TDATA_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef AXIS_ARB_STATS_EN
    .STAT_CLR(stat_clr),
    .STAT_BEATS(stat_beats),
`endif
    .bus(bus)
  );
  int total = 0, bad = 0, cyc = 0;
  int rem [N] = '{default: 0};
  int seq [N] = '{default: 0};
  int out_seq [N] = '{default: 0};
  int acc_cnt [N] = '{default: 0};
  logic [N-1:0] acc_n = '0;
  int log_id [$], log_cyc [$];
  logic [W-1:0] log_d [$];
  logic exp_v = 1'b0;
  logic [W-1:0] exp_d = '0;
  int exp_id = 0;
  function automatic void check(string name, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endfunction
  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      bus.S_AXIS_TVALID[i] = rem[i] > 0;
      bus.S_AXIS_TDATA[i*W +: W] = {8'(i), 24'(seq[i])};
    end
  endfunction
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (acc_n[i]) begin
          seq[i]++;
          if (rem[i] > 0) rem[i]--;
        end
      drive();
    end
  endtask
  task automatic clear_log();
    log_id.delete();
    log_cyc.delete();
    log_d.delete();
  endtask
  task automatic do_reset(string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_rst_tvalid"}, bus.M_AXIS_TVALID, 0);
    check({tag, "_rst_tdata"}, bus.M_AXIS_TDATA, 0);
    check({tag, "_rst_tid"}, bus.M_AXIS_TID, 0);
    check({tag, "_rst_sready"}, bus.S_AXIS_TREADY, 0);
`ifdef AXIS_ARB_STATS_EN
    check({tag, "_rst_stats"}, longint'(|stat_beats), 0);
`endif
    tick(2);
    rst_n = 1'b1;
  endtask
  // Output register model: shows the last accepted beat one cycle later, drops valid once consumed.
  always @(negedge clk) begin : mon
    int id;
    cyc++;
    if (!rst_n) begin
      exp_v = 1'b0;
      exp_d = '0;
      exp_id = 0;
      acc_n = '0;
      for (int i = 0; i < N; i++) out_seq[i] = seq[i];
    end else begin
      check("m_tvalid", bus.M_AXIS_TVALID, exp_v);
      if (exp_v) begin
        check("m_tdata", bus.M_AXIS_TDATA, exp_d);
        check("m_tid", bus.M_AXIS_TID, exp_id);
      end
      check("s_tready_onehot", longint'($countones(bus.S_AXIS_TREADY) <= 1), 1);
      if (bus.M_AXIS_TVALID && !bus.M_AXIS_TREADY) check("s_tready_stall", bus.S_AXIS_TREADY, 0);
      if (bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
        id = int'(bus.M_AXIS_TID);
        check("beat_src", bus.M_AXIS_TDATA[31:24], id);
        check("beat_seq", bus.M_AXIS_TDATA[23:0], out_seq[id] & 24'hffffff);
        out_seq[id]++;
        log_id.push_back(id);
        log_cyc.push_back(cyc);
        log_d.push_back(bus.M_AXIS_TDATA);
      end
      acc_n = bus.S_AXIS_TVALID & bus.S_AXIS_TREADY;
      if (|acc_n) begin
        exp_v = 1'b1;
        for (int i = 0; i < N; i++)
          if (acc_n[i]) begin
            exp_d = bus.S_AXIS_TDATA[i*W +: W];
            exp_id = i;
            acc_cnt[i]++;
          end
      end else if (bus.M_AXIS_TREADY) exp_v = 1'b0;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bus.M_AXIS_TREADY = 1'b1;
    drive();
    // Single source, three beats back-to-back.
    do_reset("t1");
    clear_log();
    rem[1] = 3;
    drive();
    tick(10);
    check("t1_beats", log_id.size(), 3);
    if (log_d.size() > 0) check("t1_first_data", log_d[0], 32'h0100_0000);
    for (int k = 0; k < log_id.size(); k++) begin
      check("t1_tid", log_id[k], 1);
      if (k > 0) check("t1_gap", log_cyc[k] - log_cyc[k-1], 1);
    end
    // Sink stall in the middle of the first burst of src2.
    do_reset("t3");
    clear_log();
    rem[2] = 10;
    drive();
    tick(4);
    bus.M_AXIS_TREADY = 1'b0;
    repeat (5) begin
      tick(1);
      check("t3_hold_valid", bus.M_AXIS_TVALID, 1);
      check("t3_hold_data", bus.M_AXIS_TDATA, 32'h0200_0002);
      check("t3_hold_tid", bus.M_AXIS_TID, 2);
      check("t3_hold_sready", bus.S_AXIS_TREADY[2], 0);
    end
    bus.M_AXIS_TREADY = 1'b1;
    tick(25);
    check("t3_beats", log_id.size(), 10);
    for (int k = 0; k < log_d.size(); k++) check("t3_data", log_d[k], 32'h0200_0000 + k);
    if (log_cyc.size() >= 5) begin
      check("t3_gap_resume", log_cyc[3] - log_cyc[2], 1);
      check("t3_gap_burst_end", log_cyc[4] - log_cyc[3], 2);
    end
    // src0 ends its burst early while src3 waits.
    do_reset("t4");
    clear_log();
    rem[0] = 2;
    rem[3] = 5;
    drive();
    tick(20);
    check("t4_beats", log_id.size(), 7);
    if (log_id.size() == 7) begin
      for (int k = 0; k < 7; k++) check("t4_tid", log_id[k], k < 2 ? 0 : 3);
      check("t4_gap_switch", log_cyc[2] - log_cyc[1], 3);
      for (int k = 3; k < 6; k++) check("t4_gap_burst", log_cyc[k] - log_cyc[k-1], 1);
      check("t4_gap_regrant", log_cyc[6] - log_cyc[5], 2);
    end
    // All sources streaming: rotation 0,1,2,3,0 in blocks of MB with one bubble.
    do_reset("t2");
    clear_log();
    for (int i = 0; i < N; i++) rem[i] = 1000;
    drive();
    for (int c = 0; c < 60 && log_id.size() < 20; c++) tick();
    check("t2_beats", longint'(log_id.size() >= 20), 1);
    if (log_id.size() >= 20)
      for (int k = 0; k < 20; k++) begin
        check("t2_tid", log_id[k], (k / MB) % N);
        if (k > 0) check("t2_gap", log_cyc[k] - log_cyc[k-1], (k % MB == 0) ? 2 : 1);
      end
    for (int i = 0; i < N; i++) rem[i] = 0;
    drive();
    tick(8);
    // Reset mid-burst with the pointer away from zero.
    do_reset("t5a");
    rem[2] = 1000;
    drive();
    tick(7);
    rem[1] = 1000;
    rem[3] = 1000;
    drive();
    tick(1);
    check("t5_pre_valid", bus.M_AXIS_TVALID, 1);
    do_reset("t5");
    clear_log();
    tick(30);
    check("t5_beats", longint'(log_id.size() >= 13), 1);
    if (log_id.size() >= 13)
      for (int k = 0; k < 13; k++) check("t5_tid", log_id[k], k < 4 ? 1 : k < 8 ? 2 : k < 12 ? 3 : 1);
    for (int i = 0; i < N; i++) rem[i] = 0;
    drive();
    tick(8);
`ifdef AXIS_ARB_STATS_EN
    begin
      bit hit;
      do_reset("t6");
      rem[3] = 10;
      drive();
      tick(25);
      check("t6_stat3", stat_beats[3*32 +: 32], 10);
      check("t6_stat0", stat_beats[0 +: 32], 0);
      rem[3] = 5;
      drive();
      hit = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
        @(negedge clk);
        #1;
        hit = bus.S_AXIS_TVALID[3] && bus.S_AXIS_TREADY[3];
      end
      check("t6_clear_accept_seen", hit, 1);
      stat_clr = 1'b1;
      tick(1);
      stat_clr = 1'b0;
      check("t6_stat_cleared", stat_beats[3*32 +: 32], 0);
      tick(20);
      check("t6_stat_after", stat_beats[3*32 +: 32], 4);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
